// File: rtl/lfsr_led_sequencer.sv
// LED pattern sequencer stepped by the lfsr_22 done pulse; four pattern modes,
// tick divider, 8-bit step counter with wrap pulse, and enable-driven restart.
module lfsr_led_sequencer #(
  parameter int NUM_LEDS = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_tick,
  input  logic [NUM_LEDS-1:0] i_rand,
  input  logic [1:0]          i_mode,
  output logic [NUM_LEDS-1:0] o_led,
  output logic [7:0]          o_step,
  output logic                o_busy,
  output logic                o_wrap,
  output logic [1:0]          o_state  // debug: 0 = IDLE, 1 = LOAD, 2 = RUN
);

  // i_tick is a one-cycle strobe with no back-pressure: every cycle it is high
  // in RUN counts toward the divider; ticks seen in IDLE or LOAD are dropped.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int                  DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);

  state_t              state;
  state_t              state_next;

  logic [NUM_LEDS-1:0] led;
  logic [NUM_LEDS-1:0] led_next;
  logic [7:0]          step;
  logic [7:0]          step_next;
  logic                busy;
  logic                busy_next;
  logic                wrap;
  logic                wrap_next;
  logic [DIV_W-1:0]    div;
  logic [DIV_W-1:0]    div_next;
  logic                dir_right;
  logic                dir_right_next;
  logic [1:0]          r_mode;
  logic [1:0]          r_mode_next;

  logic                step_due;
  logic                mode_same;
  logic [NUM_LEDS-1:0] rand_safe;
  logic [NUM_LEDS-1:0] led_init;

  // A step boundary is the tick that brings the divider to its terminal count.
  assign step_due  = (state == RUN) && i_enable && i_tick && (div == DIV_LAST);
  assign mode_same = (i_mode == r_mode);
  assign rand_safe = (i_rand == '0) ? LED_ONE : i_rand;

  always_comb begin
    led_init = LED_ONE;
    case (i_mode)
      2'd2:    led_init = rand_safe;
      2'd3:    led_init = '1;
      default: led_init = LED_ONE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; disable has priority over any coincident tick.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_enable) state_next = LOAD;
      end
      LOAD: begin
        state_next = i_enable ? RUN : IDLE;
      end
      RUN: begin
        if (!i_enable) begin
          state_next = IDLE;
        end else if (step_due && !mode_same) begin
          state_next = LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    led_next       = led;
    step_next      = step;
    wrap_next      = 1'b0;
    div_next       = div;
    dir_right_next = dir_right;
    r_mode_next    = r_mode;
    busy_next      = (state_next != IDLE);

    case (state)
      IDLE: begin
        led_next = '0;
      end

      LOAD: begin
        r_mode_next    = i_mode;
        step_next      = 8'd0;
        div_next       = '0;
        dir_right_next = 1'b0;
        led_next       = i_enable ? led_init : '0;
      end

      RUN: begin
        if (!i_enable) begin
          led_next = '0;
        end else if (i_tick) begin
          div_next = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
          if (step_due && mode_same) begin
            case (r_mode)
              2'd0: led_next = {led[NUM_LEDS-2:0], led[NUM_LEDS-1]};
              2'd1: begin
                // Ping-pong turns around on the edge LED, then moves away from it.
                if (!dir_right && led[NUM_LEDS-1]) begin
                  dir_right_next = 1'b1;
                  led_next       = led >> 1;
                end else if (dir_right && led[0]) begin
                  dir_right_next = 1'b0;
                  led_next       = led << 1;
                end else begin
                  led_next = dir_right ? (led >> 1) : (led << 1);
                end
              end
              2'd2:    led_next = rand_safe;
              default: led_next = ~led;
            endcase
            step_next = step + 8'd1;
            wrap_next = (step == 8'hFF);
          end
        end
      end

      default: begin
        led_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      led       <= '0;
      step      <= 8'd0;
      busy      <= 1'b0;
      wrap      <= 1'b0;
      div       <= '0;
      dir_right <= 1'b0;
      r_mode    <= 2'd0;
    end else begin
      led       <= led_next;
      step      <= step_next;
      busy      <= busy_next;
      wrap      <= wrap_next;
      div       <= div_next;
      dir_right <= dir_right_next;
      r_mode    <= r_mode_next;
    end
  end

  assign o_led   = led;
  assign o_step  = step;
  assign o_busy  = busy;
  assign o_wrap  = wrap;
  assign o_state = state;

endmodule

// File: doc/lfsr_led_sequencer.md
# lfsr_led_sequencer

Downstream consumer of `lfsr_22`. It takes the LFSR's one-cycle `o_done` pulse as a step tick and its low data bits as a random source, and drives an LED pattern through a small state machine. It supports four pattern modes, a tick divider, a step counter with a wrap pulse, and clean enable/disable. It sits between `lfsr_22` and the board LED pins.

## Interface
- `NUM_LEDS`, default 4: LED count; must be ≥ 2.
- `TICK_DIV`, default 1: number of ticks per pattern step; must be ≥ 1.
- `i_clk`  in  1: system clock; all logic is rising-edge.
- `i_reset`  in  1: asynchronous, active-high reset.
- `i_enable`  in  1: run request; level-sensitive.
- `i_tick`  in  1: step tick, one-cycle pulse (wired to `lfsr_22.o_done`).
- `i_rand`  in  NUM_LEDS: random pattern source (wired to `lfsr_22.o_data[NUM_LEDS-1:0]`).
- `i_mode`  in  2: pattern select; 0 = rotate, 1 = ping-pong, 2 = random, 3 = blink.
- `o_led`  out  NUM_LEDS: LED drive, registered.
- `o_step`  out  8: count of steps taken since the last LOAD; wraps at 256.
- `o_busy`  out  1: high in LOAD and RUN.
- `o_wrap`  out  1: one-cycle pulse when `o_step` wraps from 255 to 0.

## Operation
- **Reset** (asynchronous, immediate, any state):
  - state = IDLE
  - `o_led` = 0, `o_step` = 0, `o_busy` = 0, `o_wrap` = 0
  - tick divider = 0, direction = left, latched mode `r_mode` = 0
- **IDLE:**
  - `o_led` = 0 and `o_busy` = 0.
  - `i_tick` is ignored.
  - If `i_enable` = 1, go to LOAD.
- **LOAD** (exactly one cycle; `i_tick` is ignored):
  - Latch `i_mode` into `r_mode`. Clear `o_step` and the divider. Set direction = left.
  - Initial `o_led` by mode:
    - modes 0 and 1: `0…01`
    - mode 2: `i_rand`, or `0…01` if `i_rand` = 0
    - mode 3: all ones
  - Go to RUN. If `i_enable` = 0 during LOAD, go to IDLE instead and clear `o_led`.
- **RUN:**
  - If `i_enable` = 0: go to IDLE and clear `o_led` on that edge. This takes priority over a coincident tick.
  - Otherwise, on `i_tick` = 1:
    - If divider = `TICK_DIV`-1: clear the divider and perform a step.
    - Otherwise: increment the divider.
- **Step:**
  - If `i_mode` ≠ `r_mode`: go to LOAD. No pattern step occurs and `o_step` is not incremented.
  - Otherwise update `o_led` by mode:
    - Mode 0: rotate left; the MSB wraps into bit 0.
    - Mode 1: ping-pong.
      - Direction left with `o_led[MSB]` = 1: set direction = right and shift right.
      - Direction right with `o_led[0]` = 1: set direction = left and shift left.
      - Otherwise: shift in the current direction.
      - Resulting sequence for 4 LEDs: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
    - Mode 2: load `i_rand`; zero is replaced by `0…01`. `o_led` is never all zero in RUN.
    - Mode 3: invert `o_led`.
  - Then `o_step` <= `o_step` + 1 (mod 256). `o_wrap` = 1 on the same edge that `o_step` goes from 255 to 0, and 0 on all other edges.
- **Invariants:**
  - `i_mode` is sampled only at LOAD and at step boundaries. Mode changes between steps have no effect until the next step.
  - `o_led` is never X after reset.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `i_enable` rising, sampled at edge k:
  - `o_busy` = 1 after edge k (LOAD).
  - Initial pattern on `o_led` after edge k+1 (RUN).
- Tick-to-LED latency: with `i_tick` sampled high at edge n on a step boundary, the new `o_led`/`o_step` are visible after edge n.
- Mode-change restart: the mismatching step edge enters LOAD, and the new initial pattern appears one edge later.
- `i_enable` falling, sampled at edge k: `o_led` = 0 and `o_busy` = 0 after edge k.
- Back-to-back ticks on consecutive cycles are each honoured in RUN. A tick during LOAD is dropped.
- Reset asserted mid-RUN: outputs clear asynchronously. After deassertion the block is in IDLE.

## Test plan
- Reset release with `NUM_LEDS`=4, `TICK_DIV`=1, mode 0, enable high, 5 ticks → `o_led` = 0001 after LOAD, then 0010, 0100, 1000, 0001, 0010; `o_step` = 5.
- Mode 1, 8 ticks → `o_led` = 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100.
- Mode 2:
  - `i_rand` = 0 at LOAD → `o_led` = 0001.
  - tick with `i_rand` = 1010 → `o_led` = 1010.
  - tick with `i_rand` = 0000 → `o_led` = 0001.
- `TICK_DIV`=3, mode 3, 6 ticks → `o_led` = 1111 → 0000 after tick 3 → 1111 after tick 6; `o_step` = 2.
- 256 steps in mode 0 → `o_wrap` is high for exactly one cycle, coincident with `o_step` = 0. Mode changed to 3 mid-run → the next step restarts with `o_led` = 1111 and `o_step` = 0.
- Drop `i_enable` in the same cycle as a tick → `o_led` = 0000 and `o_busy` = 0 next cycle. Assert `i_reset` mid-RUN (between clock edges) → outputs are 0 before the next clock edge.
